// File: rtl/queue_drain_ctrl.sv
// Read-side drain for the shift-register queue: pops only when occupied, 2-cycle read_flag->out_vld, holds word while !out_rdy.
// Optional sticky overflow detection is built when QUEUE_DRAIN_OVF_EN is defined; otherwise ovf is tied low.
module queue_drain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             push,
  input  logic [WIDTH-1:0] q_dout,
  output logic             read_flag,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Occupancy mirror runs every cycle so pushes are never lost while ce is low.
  always_comb begin
    count_nxt = count;
    if (push && !read_flag) begin
      if (count != DEPTH_C) count_nxt = count + 1'b1;
    end else if (!push && read_flag) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else      count <= count_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_flag = 1'b0;
    if (ce) begin
      case (state)
        IDLE:    if (count != '0) state_nxt = ISSUE;
        ISSUE: begin
          read_flag = 1'b1;
          state_nxt = CAPTURE;
        end
        CAPTURE: state_nxt = HOLD;
        HOLD:    if (out_rdy) state_nxt = (count != '0) ? ISSUE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The queue's read data is registered, so it is sampled one cycle after ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (ce) begin
      if (state == CAPTURE) begin
        out_data <= q_dout;
        out_vld  <= 1'b1;
      end else if (state == HOLD && out_rdy) begin
        out_vld  <= 1'b0;
      end
    end
  end

`ifdef QUEUE_DRAIN_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     ovf <= 1'b0;
    else if (push && !read_flag && count == DEPTH_C) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Bench for queue_drain_ctrl: vector table, directed corner sequences, and randomized traffic vs a FIFO/count model.
module tb_queue_drain_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst, ce, push, out_rdy;
  logic [WIDTH-1:0] din, q_dout, out_data;
  logic             read_flag, out_vld, empty, full, ovf;
  logic [1:0]       count;

  int tests = 0;
  int fails = 0;

  queue_drain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .push(push), .q_dout(q_dout),
    .read_flag(read_flag), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .count(count), .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Behavioural queue with a registered read port, standing in for the real queue.
  logic [WIDTH-1:0] qmem[$];
  logic [WIDTH-1:0] qtmp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qmem.delete();
      q_dout <= '0;
    end else begin
      if (read_flag && qmem.size() > 0) begin
        qtmp = qmem.pop_front();
        q_dout <= qtmp;
      end
      if (push && qmem.size() < DEPTH) qmem.push_back(din);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_step(input logic p, input logic [WIDTH-1:0] d, input logic r, input logic c);
    @(negedge clk);
    push = p; din = d; out_rdy = r; ce = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; push = 1'b0; din = '0; out_rdy = 1'b0; ce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  typedef struct {
    logic             p;
    logic [WIDTH-1:0] d;
    logic             r;
    logic             c;
    logic             e_rf;
    logic             e_vld;
    logic [WIDTH-1:0] e_data;
    int               e_cnt;
  } vec_t;

  vec_t vec[12];

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] w, prev_data;
  logic             exp_ovf, ovf_m, acc, prev_hold;
  int               cnt_m;
  bit               seen;

  initial begin
    // Three back-to-back pushes drained with out_rdy held high.
    vec[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vec[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vec[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2};
    vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 2};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 2};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 0};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 0};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 0};

`ifdef QUEUE_DRAIN_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    rst = 1'b0; ce = 1'b1; push = 1'b0; din = '0; out_rdy = 1'b0;
    do_reset();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_rf", read_flag, 0);
    chk("reset_vld", out_vld, 0);
    chk("reset_data", out_data, 0);
    chk("reset_ovf", ovf, 0);

    for (int i = 0; i < 12; i++) begin
      run_step(vec[i].p, vec[i].d, vec[i].r, vec[i].c);
      chk($sformatf("vec%0d_rf", i), read_flag, vec[i].e_rf);
      chk($sformatf("vec%0d_vld", i), out_vld, vec[i].e_vld);
      chk($sformatf("vec%0d_data", i), out_data, vec[i].e_data);
      chk($sformatf("vec%0d_cnt", i), count, vec[i].e_cnt);
    end

    // Single word held under backpressure.
    run_step(1'b1, 8'h5A, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_step(1'b0, 8'h00, 1'b0, 1'b1);
      seen = out_vld;
    end
    chk("stall_reach_vld", out_vld, 1);
    for (int i = 0; i < 5; i++) begin
      run_step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("stall_vld", out_vld, 1);
      chk("stall_data", out_data, 8'h5A);
      chk("stall_rf", read_flag, 0);
      chk("stall_cnt", count, 0);
    end
    run_step(1'b0, 8'h00, 1'b1, 1'b1);
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_release_vld", out_vld, 0);

    // Push coincident with ISSUE while count==1.
    run_step(1'b1, 8'hA1, 1'b1, 1'b1);
    run_step(1'b0, 8'h00, 1'b1, 1'b1);
    run_step(1'b1, 8'hB2, 1'b1, 1'b1);
    chk("coinc_rf", read_flag, 1);
    chk("coinc_cnt_before", count, 1);
    run_step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("coinc_cnt_after", count, 1);
    got_q.delete();
    for (int i = 0; i < 20 && got_q.size() < 2; i++) begin
      run_step(1'b0, 8'h00, 1'b1, 1'b1);
      if (out_vld) got_q.push_back(out_data);
    end
    chk("coinc_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("coinc_word0", got_q[0], 8'hA1);
      chk("coinc_word1", got_q[1], 8'hB2);
    end
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("coinc_drained", count, 0);

    // ce low from the CAPTURE cycle.
    run_step(1'b1, 8'h77, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_step(1'b0, 8'h00, 1'b0, 1'b1);
      seen = read_flag;
    end
    chk("ce_reach_issue", read_flag, 1);
    for (int i = 0; i < 4; i++) begin
      run_step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ce_off_rf", read_flag, 0);
      chk("ce_off_vld", out_vld, 0);
    end
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ce_on_vld", out_vld, 1);
    chk("ce_on_data", out_data, 8'h77);
    run_step(1'b0, 8'h00, 1'b1, 1'b1);
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ce_release_vld", out_vld, 0);

    // Four pushes with no pops (ce low keeps the FSM from popping).
    for (int i = 0; i < 4; i++) run_step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    run_step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_cnt", count, 3);
    chk("ovf_full", full, 1);
    chk("ovf_empty", empty, 0);
    chk("ovf_flag", ovf, exp_ovf);
    run_step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_sticky", ovf, exp_ovf);
    do_reset();
    chk("ovf_reset", ovf, 0);

    // Asynchronous reset in HOLD with count==2.
    run_step(1'b1, 8'hE1, 1'b0, 1'b1);
    run_step(1'b1, 8'hE2, 1'b0, 1'b1);
    run_step(1'b1, 8'hE3, 1'b0, 1'b1);
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("hold_vld", out_vld, 1);
    chk("hold_cnt", count, 2);
    rst = 1'b0;
    #1;
    chk("arst_vld", out_vld, 0);
    chk("arst_cnt", count, 0);
    chk("arst_rf", read_flag, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("post_rst_rf", read_flag, 0);
      chk("post_rst_vld", out_vld, 0);
    end

    // Randomized traffic against a FIFO-order and occupancy model.
    do_reset();
    exp_q.delete();
    cnt_m = 0; ovf_m = 1'b0; prev_hold = 1'b0; prev_data = '0;
    for (int i = 0; i < 2000; i++) begin
      logic p, r, c;
      p = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 4) != 0);
      r = c && ($urandom_range(0, 1) == 1);
      run_step(p, 8'($urandom), r, c);
      chk("rnd_cnt", count, cnt_m);
      chk("rnd_ovf", ovf, ovf_m);
      chk("rnd_rf_ce", read_flag && !ce, 0);
      if (read_flag) chk("rnd_rf_nonempty", cnt_m != 0, 1);
      if (prev_hold) begin
        chk("rnd_hold_vld", out_vld, 1);
        chk("rnd_hold_data", out_data, prev_data);
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) chk("rnd_spurious_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("rnd_word", out_data, w);
        end
      end
      prev_hold = out_vld && !(out_rdy && ce);
      prev_data = out_data;
      acc = push && (cnt_m < DEPTH || read_flag);
      if (acc) exp_q.push_back(din);
`ifdef QUEUE_DRAIN_OVF_EN
      if (push && cnt_m == DEPTH && !read_flag) ovf_m = 1'b1;
`endif
      cnt_m = cnt_m + (acc ? 1 : 0) - (read_flag ? 1 : 0);
    end
    for (int i = 0; i < 100 && (exp_q.size() > 0 || out_vld); i++) begin
      run_step(1'b0, 8'h00, 1'b1, 1'b1);
      if (out_vld) begin
        if (exp_q.size() == 0) chk("drain_spurious_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("drain_word", out_data, w);
        end
      end
    end
    run_step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_empty_model", exp_q.size(), 0);
    chk("drain_cnt", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
